// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the core and the data-memory bus.
// Runs one req/ack transaction per memory instruction, stalls the core while
// it is outstanding and returns the extended load data to write-back.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// rejected with a misalign pulse instead of being forced aligned.
//
// state | meaning
// IDLE  | no transaction; a new access is accepted and latched here
// BUSY  | mem_req high, waiting for mem_ack or the timeout
// DONE  | one-cycle retire slot; result/flag pulses are visible here
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_rd_e,
    input  logic        d_wr_e,
    input  logic        sb,
    input  logic        sh,
    input  logic        sw,
    input  logic        lb,
    input  logic        lh,
    input  logic        lw,
    input  logic        lbu,
    input  logic        lhu,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_out_q, rdata_out_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        wr_acc, rd_acc, access, misal;
    logic [1:0]  size_new;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_ext;

    // Decode the incoming instruction: access type, size, lanes and alignment.
    always_comb begin
        wr_acc   = d_wr_e & (sb | sh | sw);
        rd_acc   = d_rd_e & (lb | lh | lw | lbu | lhu);
        access   = wr_acc | rd_acc;
        size_new = SZ_W;
        if (wr_acc) begin
            if (sb)      size_new = SZ_B;
            else if (sh) size_new = SZ_H;
        end else begin
            if (lb | lbu)      size_new = SZ_B;
            else if (lh | lhu) size_new = SZ_H;
        end
        // Lane selection only looks at the address bits that matter for the
        // size, so an unaligned access is implicitly forced aligned.
        case (size_new)
            SZ_B: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be_new    = 4'b0011 << {addr[1], 1'b0};
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misal = ((size_new == SZ_H) & addr[0]) | ((size_new == SZ_W) & (addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
    end

    // Extract and extend the load result from the returned bus word.
    always_comb begin
        case (lane_q)
            2'd0:    byte_v = mem_rdata[7:0];
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            default: byte_v = mem_rdata[31:24];
        endcase
        half_v = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_B:    ld_ext = {{24{sign_q & byte_v[7]}}, byte_v};
            SZ_H:    ld_ext = {{16{sign_q & half_v[15]}}, half_v};
            default: ld_ext = mem_rdata;
        endcase
    end

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lane_d        = lane_q;
        size_d        = size_q;
        sign_d        = sign_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_out_d   = rdata_out_q;
        rdata_valid_d = 1'b0;
        misalign_d    = 1'b0;
        bus_err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    lane_d      = addr[1:0];
                    size_d      = size_new;
                    sign_d      = ~wr_acc & (lb | lh);
                    mem_we_d    = wr_acc;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = be_new;
                    mem_wdata_d = wdata_new;
                    if (misal) begin
                        state_d     = S_DONE;
                        misalign_d  = 1'b1;
                        rdata_out_d = 32'h0;
                    end else begin
                        state_d   = S_BUSY;
                        mem_req_d = 1'b1;
                        cnt_d     = 8'h0;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_out_d   = ld_ext;
                        rdata_valid_d = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d     = S_DONE;
                    mem_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    rdata_out_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'h0;
            lane_q        <= 2'b00;
            size_q        <= SZ_B;
            sign_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_be_q      <= 4'h0;
            mem_wdata_q   <= 32'h0;
            rdata_out_q   <= 32'h0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lane_q        <= lane_d;
            size_q        <= size_d;
            sign_q        <= sign_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_out_q   <= rdata_out_d;
            rdata_valid_q <= rdata_valid_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // Stall must rise in the same IDLE cycle the instruction arrives; gating
    // with rst_n keeps it low while reset is held.
    assign stall = rst_n & (((state_q == S_IDLE) & access) | (state_q == S_BUSY));

    assign rdata_out   = rdata_out_q;
    assign rdata_valid = rdata_valid_q;
    assign misalign    = misalign_q;
    assign bus_err     = bus_err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
